csram_loader: RTL and testbench
===============================

CSRAM_LOADER -- requirements
Module: csram_loader

Interface
REQ-001 Parameter NUM_NEURONS, default 256, SHALL be the number of CSRAM words loaded per load operation.
REQ-002 Parameter WIDTH, default 367, SHALL be the CSRAM word width in bits.
REQ-003 Parameter WRITE_WIDTH, default 9, SHALL be the input chunk width in bits; CHUNKS = ceil(WIDTH/WRITE_WIDTH), i.e. 41 at defaults.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 start  input  1  SHALL be a one-cycle load-request pulse.
REQ-007 in_valid  input  1  SHALL mark in_data as valid.
REQ-008 in_data  input  WRITE_WIDTH  SHALL carry one configuration chunk.
REQ-009 in_ready  output  1  SHALL indicate the block accepts a chunk this cycle.
REQ-010 rd_address  input  $clog2(NUM_NEURONS)  SHALL be the core controller's CSRAM read address.
REQ-011 csram_wen  output  1  SHALL be the CSRAM write enable.
REQ-012 csram_address  output  $clog2(NUM_NEURONS)  SHALL be the CSRAM address.
REQ-013 csram_data  output  WIDTH  SHALL be the CSRAM write data.
REQ-014 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-015 done  output  1  SHALL pulse for one cycle when the final word has been written.

Function
REQ-016 The block SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-017 IDLE: in_ready=0 and csram_wen=0; csram_address SHALL equal rd_address combinationally; start=1 SHALL move to COLLECT with word_cnt=0 and chunk_cnt=0.
REQ-018 COLLECT: in_ready=1; a chunk is accepted on any cycle with in_valid and in_ready both high.
REQ-019 Accepted chunk k SHALL be stored at word bits [k*WRITE_WIDTH +: WRITE_WIDTH], LSB-first; bits at or above WIDTH in the last chunk SHALL be discarded.
REQ-020 When chunk CHUNKS-1 is accepted, the next state SHALL be WRITE and chunk_cnt SHALL clear to 0; otherwise chunk_cnt increments by 1.
REQ-021 in_valid=0 in COLLECT SHALL stall the block with no state change and no timeout.
REQ-022 WRITE: lasts exactly one cycle, with csram_wen=1, csram_address=word_cnt, csram_data=assembled word and in_ready=0; all three outputs are registered and stable for the whole cycle, so the CSRAM falling-edge capture sees settled values.
REQ-023 From WRITE, if word_cnt==NUM_NEURONS-1 the next state SHALL be DONE; otherwise word_cnt increments and the next state is COLLECT.
REQ-024 DONE: done=1 for exactly one cycle, then the next state SHALL be IDLE.
REQ-025 In COLLECT, WRITE and DONE, csram_address SHALL be word_cnt and rd_address SHALL be ignored.
REQ-026 start asserted outside IDLE SHALL be ignored and SHALL not restart the count.
REQ-027 A chunk offered in IDLE, WRITE or DONE SHALL not be accepted, because in_ready=0.
REQ-028 Minimum load latency SHALL be NUM_NEURONS*(CHUNKS+1)+1 cycles from the start cycle to the done cycle, with in_valid held high.
REQ-029 The assembly register SHALL not be cleared between words; every bit below WIDTH is overwritten before each WRITE.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, word_cnt=0, chunk_cnt=0, assembly register=0, csram_wen=0, csram_data=0, in_ready=0, busy=0 and done=0; csram_address SHALL follow rd_address.
REQ-031 Reset asserted during COLLECT or WRITE SHALL abort the load with no further CSRAM write; words already written SHALL remain in CSRAM.
REQ-032 After rst_n deasserts, the block SHALL act on start no earlier than the first rising clock edge.

Verification (NUM_NEURONS=4, WIDTH=20, WRITE_WIDTH=8, so CHUNKS=3)
REQ-033 Full load: start, then chunks 0x11,0x22,0x33 repeating with in_valid held high -> four writes of 0x32211 at addresses 0..3, each csram_wen high for 1 cycle; done on cycle 17 after start; busy high on cycles 1..17.
REQ-034 Backpressure: in_valid dropped for 5 cycles after chunk 1 of word 2 -> no write during the gap; word 2 data correct; done delayed by exactly 5 cycles.
REQ-035 Truncation: last chunk 0xFF for word 0 -> csram_data[19:16]=0xF and nothing is written beyond bit 19.
REQ-036 Start while busy: second start pulse during word 1 -> word_cnt unaffected; exactly 4 writes and 1 done pulse.
REQ-037 Async reset: rst_n low mid-word 2 without a clock edge -> csram_wen=0, busy=0 and in_ready=0 immediately; no write to address 2; a fresh start reloads from address 0.
REQ-038 Idle pass-through: rd_address=3 while IDLE -> csram_address=3 and csram_wen=0 in the same cycle; during a load csram_address=word_cnt regardless of rd_address.

Source files
------------

// File: rtl/csram_loader_if.sv
// ---------------------------------------------------------------------------
// csram_loader_if
//
// Chunk-stream handshake between a configuration source and csram_loader.
// The source raises start for one cycle to request a load, then offers
// chunks on in_data qualified by in_valid.  A chunk is consumed on every
// cycle where in_valid and in_ready are both high.
//
// Signals
//   start     source -> loader  one-cycle load request
//   in_valid  source -> loader  in_data holds a chunk
//   in_data   source -> loader  one WRITE_WIDTH-bit configuration chunk
//   in_ready  loader -> source  loader takes a chunk this cycle
//
// Modports
//   master : the chunk source (drives start/in_valid/in_data)
//   slave  : the loader (drives in_ready)
// ---------------------------------------------------------------------------
interface csram_loader_if #(
    parameter int WRITE_WIDTH = 9
);

    logic                   start;
    logic                   in_valid;
    logic [WRITE_WIDTH-1:0] in_data;
    logic                   in_ready;

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/csram_loader.sv
// ---------------------------------------------------------------------------
// csram_loader
//
// Fills a neuron core's CSRAM from a narrow configuration stream.  Each
// CSRAM word of WIDTH bits arrives as CHUNKS = ceil(WIDTH/WRITE_WIDTH)
// chunks, least-significant chunk first.  Once a word is complete it is
// written with a single-cycle registered write strobe, and after
// NUM_NEURONS words the block pulses done and returns to idle.  While idle
// the CSRAM address port is handed back to the core controller.
//
// Parameters
//   NUM_NEURONS  words written per load operation
//   WIDTH        CSRAM word width in bits
//   WRITE_WIDTH  chunk width in bits
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_if        chunk stream (start, in_valid, in_data, in_ready)
//   rd_address     core controller's CSRAM read address
//   csram_wen      CSRAM write enable
//   csram_address  CSRAM address (rd_address when idle, word_cnt otherwise)
//   csram_data     CSRAM write data
//   busy           high whenever a load is in progress
//   done           one-cycle pulse after the final word has been written
// ---------------------------------------------------------------------------
module csram_loader #(
    parameter int NUM_NEURONS = 256,
    parameter int WIDTH       = 367,
    parameter int WRITE_WIDTH = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    csram_loader_if.slave                  load_if,
    input  logic [$clog2(NUM_NEURONS)-1:0] rd_address,
    output logic                           csram_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] csram_address,
    output logic [WIDTH-1:0]               csram_data,
    output logic                           busy,
    output logic                           done
);

    localparam int ADDR_W  = $clog2(NUM_NEURONS);
    localparam int CHUNKS  = (WIDTH + WRITE_WIDTH - 1) / WRITE_WIDTH;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  word_q;
    logic [ADDR_W-1:0]  word_d;
    logic [CHUNK_W-1:0] chunk_q;
    logic [CHUNK_W-1:0] chunk_d;
    logic [WIDTH-1:0]   asm_q;
    logic [WIDTH-1:0]   asm_d;
    logic [WIDTH-1:0]   data_q;
    logic               wen_q;
    logic               wen_d;
    logic               load_data;
    logic               accept;

    // The block only listens to the stream while collecting, so a chunk
    // offered during IDLE, WRITE or DONE is simply left on the bus.
    assign load_if.in_ready = (state_q == COLLECT);
    assign accept           = load_if.in_valid && (state_q == COLLECT);

    // Chunk placement is resolved per word bit: bit i always comes from
    // chunk i/WRITE_WIDTH, bit i%WRITE_WIDTH.  Building it this way means
    // the surplus top bits of the final chunk never have a destination, so
    // they are dropped without any out-of-range part-select.  The assembly
    // register is never cleared because every bit is rewritten per word.
    for (genvar i = 0; i < WIDTH; i++) begin : g_asm_bit
        assign asm_d[i] = (accept && (chunk_q == CHUNK_W'(i / WRITE_WIDTH)))
                          ? load_if.in_data[i % WRITE_WIDTH]
                          : asm_q[i];
    end

    // State, counters and the registered CSRAM write port.  The write data
    // and strobe are loaded on the edge that accepts the final chunk, so
    // they are settled for the whole WRITE cycle and the CSRAM's
    // falling-edge capture never sees them move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            chunk_q <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            chunk_q <= chunk_d;
            asm_q   <= asm_d;
            wen_q   <= wen_d;
            if (load_data) begin
                data_q <= asm_d;
            end
        end
    end

    // Next-state logic.  A stalled stream in COLLECT just holds everything,
    // and start is only looked at in IDLE so a stray pulse mid-load cannot
    // rewind the word counter.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        chunk_d   = chunk_q;
        wen_d     = 1'b0;
        load_data = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_if.start) begin
                    state_d = COLLECT;
                    word_d  = '0;
                    chunk_d = '0;
                end
            end

            COLLECT: begin
                if (accept) begin
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d   = '0;
                        state_d   = WRITE;
                        wen_d     = 1'b1;
                        load_data = 1'b1;
                    end else begin
                        chunk_d = chunk_q + CHUNK_W'(1);
                    end
                end
            end

            WRITE: begin
                if (word_q == LAST_WORD) begin
                    state_d = DONE;
                end else begin
                    word_d  = word_q + ADDR_W'(1);
                    state_d = COLLECT;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The address port belongs to the core controller only while idle;
    // during a load it tracks the word being assembled or written.
    assign csram_address = (state_q == IDLE) ? rd_address : word_q;
    assign csram_wen     = wen_q;
    assign csram_data    = data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_csram_loader.sv
// ---------------------------------------------------------------------------
// tb_csram_loader
//
// Directed/randomized bench for csram_loader at NUM_NEURONS=4, WIDTH=20,
// WRITE_WIDTH=8 (three chunks per word).  A CSRAM model logs every write on
// the falling edge; expected words are rebuilt from the chunk table with
// plain arithmetic and the expected done time from the load-latency rule.
// ---------------------------------------------------------------------------
module tb_csram_loader;

    localparam int N  = 4;
    localparam int W  = 20;
    localparam int WW = 8;
    localparam int C  = 3;
    localparam int AW = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] rd_address;
    logic          csram_wen;
    logic [AW-1:0] csram_address;
    logic [W-1:0]  csram_data;
    logic          busy;
    logic          done;

    csram_loader_if #(.WRITE_WIDTH(WW)) lif ();

    csram_loader #(
        .NUM_NEURONS (N),
        .WIDTH       (W),
        .WRITE_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_if       (lif),
        .rd_address    (rd_address),
        .csram_wen     (csram_wen),
        .csram_address (csram_address),
        .csram_data    (csram_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int cycle      = 0;
    int done_count = 0;

    int           wr_addr_q[$];
    logic [W-1:0] wr_data_q[$];
    logic [WW-1:0] chunks[N][C];

    // Edge counter used to time the done pulse relative to start.
    always @(posedge clk) cycle++;

    // CSRAM model: captures on the falling edge like the real macro.
    always @(negedge clk) begin
        if (csram_wen === 1'b1) begin
            wr_addr_q.push_back(int'(csram_address));
            wr_data_q.push_back(csram_data);
        end
        if (done === 1'b1) done_count++;
    end

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected CSRAM word: chunks summed at their bit offsets, cut to WIDTH.
    function automatic logic [W-1:0] model_word(input int w);
        longint acc;
        acc = 0;
        for (int k = 0; k < C; k++) acc += longint'(chunks[w][k]) << (k * WW);
        acc = acc % (longint'(1) << W);
        return W'(acc);
    endfunction

    task automatic fill_random();
        for (int w = 0; w < N; w++)
            for (int k = 0; k < C; k++) chunks[w][k] = WW'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One load: optional in_valid gap before chunk stall_chunk of stall_word,
    // optional stray start with chunk 1 of restart_word, optional early exit
    // right after chunk abort_chunk of abort_word is accepted.
    task automatic applyStimulus(input int stall_word, input int stall_chunk,
                                 input int stall_len, input int restart_word,
                                 input int abort_word, input int abort_chunk);
        int start_cycle;
        int budget;
        int exp_lat;
        logic acc;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_count = 0;
        exp_lat = N * (C + 1) + 1 + ((stall_word >= 0) ? stall_len : 0);

        lif.start   = 1'b1;
        start_cycle = cycle;
        step();
        lif.start   = 1'b0;

        for (int w = 0; w < N; w++) begin
            for (int k = 0; k < C; k++) begin
                if (w == stall_word && k == stall_chunk) begin
                    lif.in_valid = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        lif.in_data = WW'($urandom);
                        checkOutput("stall_no_write", csram_wen, 1'b0);
                        step();
                    end
                end
                lif.in_valid = 1'b1;
                lif.in_data  = chunks[w][k];
                rd_address   = AW'($urandom);
                if (w == restart_word && k == 1) lif.start = 1'b1;
                budget = 0;
                do begin
                    checkOutput("busy_load", busy, 1'b1);
                    acc = lif.in_ready;
                    step();
                    lif.start = 1'b0;
                    budget++;
                end while (!acc && budget < 10);
                checkOutput("accept_timeout", acc, 1'b1);
                if (w == abort_word && k == abort_chunk) begin
                    lif.in_valid = 1'b0;
                    return;
                end
            end
        end
        lif.in_valid = 1'b1;
        lif.in_data  = WW'($urandom);

        budget = 0;
        while (done !== 1'b1 && budget < 50) begin
            checkOutput("busy_wait", busy, 1'b1);
            step();
            budget++;
        end
        lif.in_valid = 1'b0;
        checkOutput("done_latency", 64'(cycle - start_cycle), 64'(exp_lat));
        checkOutput("busy_at_done", busy, 1'b1);
        step();
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("busy_after", busy, 1'b0);
        checkOutput("done_pulses", 64'(done_count), 64'd1);
        checkOutput("write_count", 64'(wr_addr_q.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            checkOutput("write_addr", 64'(wr_addr_q[i]), 64'(i));
            checkOutput("write_data", wr_data_q[i], model_word(i));
        end
    endtask

    initial begin
        lif.start    = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        rd_address   = '0;

        // Reset state
        #2 rst_n = 1'b0;
        rd_address = 2'd1;
        #1;
        checkOutput("rst_wen", csram_wen, 1'b0);
        checkOutput("rst_data", csram_data, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_in_ready", lif.in_ready, 1'b0);
        checkOutput("rst_addr", csram_address, 2'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Idle pass-through, chunks offered while idle are ignored
        wr_addr_q.delete();
        lif.in_valid = 1'b1;
        rd_address   = 2'd3;
        #1;
        checkOutput("idle_addr3", csram_address, 2'd3);
        checkOutput("idle_wen", csram_wen, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_address  = AW'($urandom);
            lif.in_data = WW'($urandom);
            #1;
            checkOutput("idle_addr_rand", csram_address, rd_address);
            checkOutput("idle_in_ready", lif.in_ready, 1'b0);
            step();
        end
        lif.in_valid = 1'b0;
        checkOutput("idle_no_write", 64'(wr_addr_q.size()), 64'd0);
        $display("[TB] idle checks complete");

        // Full load with a fixed pattern
        for (int w = 0; w < N; w++) begin
            chunks[w][0] = 8'h11;
            chunks[w][1] = 8'h22;
            chunks[w][2] = 8'h33;
        end
        applyStimulus(-1, 0, 0, -1, -1, 0);
        for (int i = 0; i < N; i++) checkOutput("fixed_word", wr_data_q[i], 20'h32211);

        // Backpressure: gap after chunk 1 of word 2
        fill_random();
        applyStimulus(2, 2, 5, -1, -1, 0);

        // Truncation of the last chunk
        fill_random();
        chunks[0][2] = 8'hFF;
        applyStimulus(-1, 0, 0, -1, -1, 0);
        begin
            logic [W-1:0] d0;
            d0 = wr_data_q[0];
            checkOutput("trunc_top", d0[19:16], 4'hF);
        end

        // Stray start during word 1
        fill_random();
        applyStimulus(-1, 0, 0, 1, -1, 0);

        // Async reset mid-word 2
        fill_random();
        applyStimulus(-1, 0, 0, -1, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_wen", csram_wen, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_in_ready", lif.in_ready, 1'b0);
        checkOutput("arst_data", csram_data, '0);
        checkOutput("arst_addr", csram_address, rd_address);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        step();
        checkOutput("arst_writes", 64'(wr_addr_q.size()), 64'd2);
        checkOutput("arst_addr0", 64'(wr_addr_q[0]), 64'd0);
        checkOutput("arst_addr1", 64'(wr_addr_q[1]), 64'd1);
        checkOutput("arst_idle", busy, 1'b0);

        // Fresh loads after reset, random data
        fill_random();
        applyStimulus(-1, 0, 0, -1, -1, 0);
        fill_random();
        applyStimulus(1, 1, 3, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
